// File: rtl/axi_burst_pkg.sv
// Shared AXI burst constants, FSM state type and the 4 KiB boundary helper
// used by the AR issuer.
package axi_burst_pkg;

  localparam int Axi4kLog    = 12;
  localparam int AxiMaxBeats = 256;
  localparam int AxiLenWidth = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_e;

  // Beats left before the next 4 KiB page; the address is assumed beat-aligned,
  // so the result is always at least 1.
  function automatic logic [Axi4kLog:0] beats_to_4k(
    input logic [Axi4kLog-1:0] addr_lo,
    input int unsigned         dwbl
  );
    logic [Axi4kLog:0] span;
    span = {1'b1, {Axi4kLog{1'b0}}} - {1'b0, addr_lo};
    return span >> dwbl;
  endfunction

endpackage

// File: rtl/axi_outstanding_counter.sv
// Up/down counter of in-flight AR bursts; full_after looks at the count as it
// will be next cycle so the issuer can decide a pop or a new arvalid now.
module axi_outstanding_counter #(
  parameter int MaxOutstanding   = 16,
  parameter int OutstandingWidth = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inc,
  input  logic                        dec,
  output logic [OutstandingWidth-1:0] count,
  output logic                        full_after
);

  localparam logic [OutstandingWidth-1:0] MaxCount = OutstandingWidth'(MaxOutstanding);
  localparam logic [OutstandingWidth-1:0] One      = OutstandingWidth'(1);

  logic [OutstandingWidth-1:0] count_reg;
  logic [OutstandingWidth-1:0] count_next;
  logic                        dec_eff;

  // A completion with nothing in flight is dropped rather than wrapping.
  always_comb begin
    dec_eff    = dec && (count_reg != '0);
    count_next = count_reg;
    if (inc && !dec_eff) begin
      count_next = count_reg + One;
    end else if (!inc && dec_eff) begin
      count_next = count_reg - One;
    end
  end

  assign full_after = (count_next >= MaxCount);
  assign count      = count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/burst_axi_ar_issuer.sv
// Turns {burst_len, base_addr} requests into AXI AR bursts, splitting at 4 KiB
// pages and the 256-beat limit while capping the number of bursts in flight.
module burst_axi_ar_issuer
  import axi_burst_pkg::*;
#(
  parameter int AddrWidth         = 64,
  parameter int DataWidthBytesLog = 6,
  parameter int BurstLenWidth     = 8,
  parameter int MaxOutstanding    = 16,
  parameter int OutstandingWidth  = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [BurstLenWidth+AddrWidth-1:0] req_dout,
  input  logic                               req_empty_n,
  output logic                               req_read,
  output logic [AddrWidth-1:0]               m_axi_araddr,
  output logic [AxiLenWidth-1:0]             m_axi_arlen,
  output logic                               m_axi_arvalid,
  input  logic                               m_axi_arready,
  input  logic                               r_burst_done,
  output logic [OutstandingWidth-1:0]        outstanding,
  output logic                               idle
);

  localparam logic [AddrWidth-1:0] BeatMask =
    (AddrWidth'(1) << DataWidthBytesLog) - AddrWidth'(1);
  localparam logic [BurstLenWidth:0] RemOne = (BurstLenWidth+1)'(1);

  issue_state_e             state_reg;
  logic [AddrWidth-1:0]     cur_addr_reg;
  logic [BurstLenWidth:0]   remaining_reg;
  logic [AddrWidth-1:0]     araddr_reg;
  logic [AxiLenWidth-1:0]   arlen_reg;
  logic                     arvalid_reg;

  logic                     hs;
  logic                     full_after;
  logic                     can_pop;
  logic                     last_sub;
  logic [AddrWidth-1:0]     pop_addr;
  logic [AddrWidth-1:0]     next_addr;
  logic [BurstLenWidth:0]   pop_rem;
  logic [BurstLenWidth:0]   next_rem;
  logic [8:0]               cur_sub;
  logic [8:0]               next_sub;
  logic [8:0]               pop_sub;

  function automatic logic [8:0] sub_beats_of(
    input logic [AddrWidth-1:0]   addr,
    input logic [BurstLenWidth:0] rem
  );
    logic [16:0] lim;
    logic [16:0] b4k;
    lim = 17'(rem);
    b4k = 17'(beats_to_4k(addr[Axi4kLog-1:0], DataWidthBytesLog));
    if (b4k < lim) lim = b4k;
    if (17'(AxiMaxBeats) < lim) lim = 17'(AxiMaxBeats);
    return lim[8:0];
  endfunction

  assign hs        = arvalid_reg && m_axi_arready;
  assign pop_addr  = req_dout[AddrWidth-1:0] & ~BeatMask;
  assign pop_rem   = {1'b0, req_dout[AddrWidth +: BurstLenWidth]} + RemOne;
  assign pop_sub   = sub_beats_of(pop_addr, pop_rem);
  // cur_addr/remaining always describe the sub-burst currently on the bus.
  assign cur_sub   = sub_beats_of(cur_addr_reg, remaining_reg);
  assign next_addr = cur_addr_reg + (AddrWidth'(cur_sub) << DataWidthBytesLog);
  assign next_rem  = remaining_reg - (BurstLenWidth+1)'(cur_sub);
  assign next_sub  = sub_beats_of(next_addr, next_rem);
  assign last_sub  = (next_rem == '0);
  assign can_pop   = req_empty_n && !full_after;

  always_comb begin
    req_read = 1'b0;
    if (!rst) begin
      if (state_reg == ST_IDLE) begin
        req_read = can_pop;
      end else if (hs && last_sub) begin
        req_read = can_pop;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      araddr_reg    <= '0;
      arlen_reg     <= '0;
      arvalid_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_read) begin
            cur_addr_reg  <= pop_addr;
            remaining_reg <= pop_rem;
            araddr_reg    <= pop_addr;
            arlen_reg     <= AxiLenWidth'(pop_sub - 9'd1);
            arvalid_reg   <= 1'b1;
            state_reg     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            if (!last_sub) begin
              // Next piece is staged even when no slot is free; arvalid waits.
              cur_addr_reg  <= next_addr;
              remaining_reg <= next_rem;
              araddr_reg    <= next_addr;
              arlen_reg     <= AxiLenWidth'(next_sub - 9'd1);
              arvalid_reg   <= !full_after;
            end else if (req_read) begin
              cur_addr_reg  <= pop_addr;
              remaining_reg <= pop_rem;
              araddr_reg    <= pop_addr;
              arlen_reg     <= AxiLenWidth'(pop_sub - 9'd1);
              arvalid_reg   <= 1'b1;
            end else begin
              remaining_reg <= '0;
              arvalid_reg   <= 1'b0;
              state_reg     <= ST_IDLE;
            end
          end else if (!arvalid_reg && !full_after) begin
            arvalid_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  axi_outstanding_counter #(
    .MaxOutstanding  (MaxOutstanding),
    .OutstandingWidth(OutstandingWidth)
  ) u_outstanding (
    .clk       (clk),
    .rst       (rst),
    .inc       (hs),
    .dec       (r_burst_done),
    .count     (outstanding),
    .full_after(full_after)
  );

  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arlen   = arlen_reg;
  assign m_axi_arvalid = arvalid_reg;
  assign idle          = (state_reg == ST_IDLE) && (outstanding == '0);

endmodule

// File: tb/tb_burst_axi_ar_issuer.sv
// Bench for burst_axi_ar_issuer: directed split/limit/stall/reset scenarios plus
// a randomized run scored against a plain-arithmetic split model.
module tb_burst_axi_ar_issuer;

  localparam int AW   = 64;
  localparam int DWBL = 2;
  localparam int BLW  = 10;
  localparam int MO   = 2;
  localparam int OW   = 2;
  localparam int BEAT = 1 << DWBL;

  typedef struct { logic [63:0] addr; logic [9:0] len; } req_t;
  typedef struct { logic [63:0] addr; logic [7:0] len; int cyc; } ar_t;
  typedef struct {
    logic rd, empty_n, vld, rdy, done, idle;
    logic [63:0] addr;
    logic [7:0] len;
    logic [OW-1:0] outs;
  } smp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [BLW+AW-1:0] req_dout = '0;
  logic              req_empty_n = 1'b0;
  logic              req_read;
  logic [AW-1:0]     m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic              m_axi_arvalid;
  logic              m_axi_arready = 1'b0;
  logic              r_burst_done = 1'b0;
  logic [OW-1:0]     outstanding;
  logic              idle;

  req_t src_q[$];
  ar_t  hs_q[$];
  ar_t  exp_q[$];
  int   pop_q[$];
  smp_t tr[$];

  int checks = 0;
  int errors = 0;
  int tb_outs = 0;
  int rdy_mode = 0;
  int win_lo = 0;
  int win_hi = 0;
  bit rdy_in_win = 1'b0;
  bit done_rand = 1'b0;
  bit done_once = 1'b0;
  bit empty_rand = 1'b0;

  always #5 clk = ~clk;

  burst_axi_ar_issuer #(
    .AddrWidth(AW), .DataWidthBytesLog(DWBL), .BurstLenWidth(BLW),
    .MaxOutstanding(MO), .OutstandingWidth(OW)
  ) dut (
    .clk(clk), .rst(rst), .req_dout(req_dout), .req_empty_n(req_empty_n),
    .req_read(req_read), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .r_burst_done(r_burst_done), .outstanding(outstanding), .idle(idle)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Reference: walk the request in beats, cutting at pages and at 256 beats.
  function automatic void model_split(input logic [63:0] addr, input int len);
    logic [63:0] a;
    int beats, to4k, n;
    ar_t e;
    a = addr & ~64'(BEAT - 1);
    beats = len + 1;
    while (beats > 0) begin
      to4k = (4096 - int'(a % 4096)) / BEAT;
      n = beats;
      if (to4k < n) n = to4k;
      if (256 < n) n = 256;
      e.addr = a;
      e.len = 8'(n - 1);
      e.cyc = 0;
      exp_q.push_back(e);
      a = a + 64'(n * BEAT);
      beats -= n;
    end
  endfunction

  task automatic clear_trace();
    tr.delete();
    hs_q.delete();
    pop_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_empty_n = 1'b0;
    req_dout = '0;
    m_axi_arready = 1'b0;
    r_burst_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tb_outs = 0;
    src_q.delete();
    exp_q.delete();
    clear_trace();
    rdy_mode = 0;
    done_rand = 1'b0;
    done_once = 1'b0;
    empty_rand = 1'b0;
  endtask

  // Drives one cycle at a time from src_q and the ready/done policy, records a trace.
  task automatic run(input int n);
    smp_t s;
    ar_t h;
    int cyc;
    for (int c = 0; c < n; c++) begin
      cyc = tr.size();
      req_empty_n = (src_q.size() > 0) && (!empty_rand || ($urandom_range(3) != 0));
      req_dout = (src_q.size() > 0) ? {src_q[0].len, src_q[0].addr} : '0;
      case (rdy_mode)
        0: m_axi_arready = 1'b1;
        1: m_axi_arready = ($urandom_range(2) != 0);
        default: m_axi_arready = (cyc >= win_lo && cyc < win_hi) ? rdy_in_win : !rdy_in_win;
      endcase
      r_burst_done = 1'b0;
      if (done_once && tb_outs > 0) begin
        r_burst_done = 1'b1;
        done_once = 1'b0;
      end else if (done_rand && tb_outs > 0) begin
        r_burst_done = ($urandom_range(2) == 0);
      end
      #1;
      s.rd = req_read; s.empty_n = req_empty_n; s.vld = m_axi_arvalid;
      s.rdy = m_axi_arready; s.done = r_burst_done; s.idle = idle;
      s.addr = m_axi_araddr; s.len = m_axi_arlen; s.outs = outstanding;
      tr.push_back(s);
      if (s.vld && s.rdy) begin
        h.addr = s.addr; h.len = s.len; h.cyc = cyc;
        hs_q.push_back(h);
        tb_outs++;
      end
      if (s.done) tb_outs--;
      if (s.rd && s.empty_n) begin
        pop_q.push_back(cyc);
        src_q.delete(0);
      end
      @(posedge clk);
      #1;
    end
    req_empty_n = 1'b0;
    r_burst_done = 1'b0;
  endtask

  task automatic push_req(input logic [63:0] addr, input int len);
    req_t r;
    r.addr = addr;
    r.len = 10'(len);
    src_q.push_back(r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_empty_n = 1'b1;
    req_dout = {10'd0, 64'h40};
    m_axi_arready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (req_read !== 1'b0) begin errors++; $display("FAIL reset_req_read got %b want 0", req_read); end
    checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b want 0", m_axi_arvalid); end
    checks++; if (m_axi_araddr !== 64'h0) begin errors++; $display("FAIL reset_araddr got %h want 0", m_axi_araddr); end
    checks++; if (m_axi_arlen !== 8'h0) begin errors++; $display("FAIL reset_arlen got %h want 0", m_axi_arlen); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
    req_empty_n = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int nv;
    do_reset();
    push_req(64'h1000, 3);
    run(6);
    checks++;
    if (hs_q.size() != 1) begin
      errors++; $display("FAIL single_count got %0d want 1", hs_q.size());
    end else begin
      checks++;
      if (hs_q[0].addr !== 64'h1000 || hs_q[0].len !== 8'd3) begin
        errors++; $display("FAIL single_ar got %h/%0d want 1000/3", hs_q[0].addr, hs_q[0].len);
      end
      checks++;
      if (pop_q.size() != 1 || hs_q[0].cyc != pop_q[0] + 1) begin
        errors++; $display("FAIL single_latency got pops=%0d ar_cyc=%0d want 1 pop, ar one cycle later", pop_q.size(), hs_q[0].cyc);
      end
    end
    nv = 0;
    foreach (tr[i]) nv += int'(tr[i].vld);
    checks++; if (nv != 1) begin errors++; $display("FAIL single_arvalid_cycles got %0d want 1", nv); end
    clear_trace();
    done_once = 1'b1;
    run(3);
    checks++;
    if (tr[2].outs !== '0 || tr[2].idle !== 1'b1) begin
      errors++; $display("FAIL single_drain got outs=%0d idle=%b want 0/1", tr[2].outs, tr[2].idle);
    end
  endtask

  task automatic test_align();
    do_reset();
    push_req(64'h1007, 1);
    run(5);
    checks++;
    if (hs_q.size() != 1 || hs_q[0].addr !== 64'h1004 || hs_q[0].len !== 8'd1) begin
      errors++; $display("FAIL align got n=%0d %h/%0d want 1 AR 1004/1", hs_q.size(), hs_q[0].addr, hs_q[0].len);
    end
  endtask

  task automatic test_4k_split();
    do_reset();
    push_req(64'h1FF8, 5);
    run(6);
    checks++;
    if (hs_q.size() != 2) begin
      errors++; $display("FAIL split4k_count got %0d want 2", hs_q.size());
    end else begin
      checks++;
      if (hs_q[0].addr !== 64'h1FF8 || hs_q[0].len !== 8'd1) begin
        errors++; $display("FAIL split4k_first got %h/%0d want 1ff8/1", hs_q[0].addr, hs_q[0].len);
      end
      checks++;
      if (hs_q[1].addr !== 64'h2000 || hs_q[1].len !== 8'd3 || hs_q[1].cyc != hs_q[0].cyc + 1) begin
        errors++; $display("FAIL split4k_second got %h/%0d cyc %0d want 2000/3 cyc %0d", hs_q[1].addr, hs_q[1].len, hs_q[1].cyc, hs_q[0].cyc + 1);
      end
    end
    checks++; if (pop_q.size() != 1) begin errors++; $display("FAIL split4k_pops got %0d want 1", pop_q.size()); end
  endtask

  task automatic test_256_limit();
    do_reset();
    push_req(64'h0, 299);
    run(6);
    checks++;
    if (hs_q.size() != 2) begin
      errors++; $display("FAIL max256_count got %0d want 2", hs_q.size());
    end else begin
      checks++;
      if (hs_q[0].addr !== 64'h0 || hs_q[0].len !== 8'd255) begin
        errors++; $display("FAIL max256_first got %h/%0d want 0/255", hs_q[0].addr, hs_q[0].len);
      end
      checks++;
      if (hs_q[1].addr !== 64'h400 || hs_q[1].len !== 8'd43) begin
        errors++; $display("FAIL max256_second got %h/%0d want 400/43", hs_q[1].addr, hs_q[1].len);
      end
    end
  endtask

  task automatic test_outstanding();
    do_reset();
    push_req(64'h0, 0);
    push_req(64'h40, 0);
    push_req(64'h80, 0);
    run(8);
    checks++; if (hs_q.size() != 2) begin errors++; $display("FAIL outs_ar_count got %0d want 2", hs_q.size()); end
    checks++; if (tr[7].outs !== OW'(2)) begin errors++; $display("FAIL outs_full got %0d want 2", tr[7].outs); end
    checks++; if (src_q.size() != 1) begin errors++; $display("FAIL outs_unpopped got %0d want 1", src_q.size()); end
    clear_trace();
    done_once = 1'b1;
    run(6);
    checks++;
    if (hs_q.size() != 1 || hs_q[0].addr !== 64'h80 || hs_q[0].len !== 8'd0) begin
      errors++; $display("FAIL outs_third got n=%0d %h/%0d want 1 AR 80/0", hs_q.size(), hs_q[0].addr, hs_q[0].len);
    end
    checks++; if (tr[5].outs !== OW'(2)) begin errors++; $display("FAIL outs_refill got %0d want 2", tr[5].outs); end
  endtask

  task automatic test_stall();
    do_reset();
    push_req(64'h1FF8, 5);
    rdy_mode = 2; win_lo = 0; win_hi = 6; rdy_in_win = 1'b0;
    run(10);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (tr[c].vld !== 1'b1 || tr[c].addr !== 64'h1FF8 || tr[c].len !== 8'd1) begin
        errors++; $display("FAIL stall_hold cyc %0d got v=%b %h/%0d want 1 1ff8/1", c, tr[c].vld, tr[c].addr, tr[c].len);
      end
    end
    checks++;
    if (hs_q.size() != 2 || hs_q[0].cyc != 6 || hs_q[1].cyc != 7 || hs_q[1].addr !== 64'h2000) begin
      errors++; $display("FAIL stall_order got n=%0d c0=%0d c1=%0d a1=%h want 2 6 7 2000", hs_q.size(), hs_q[0].cyc, hs_q[1].cyc, hs_q[1].addr);
    end
  endtask

  task automatic test_reset_mid_split();
    do_reset();
    push_req(64'h1FF8, 5);
    rdy_mode = 2; win_lo = 1; win_hi = 2; rdy_in_win = 1'b1;
    run(4);
    checks++;
    if (tr[3].vld !== 1'b1 || tr[3].addr !== 64'h2000) begin
      errors++; $display("FAIL midrst_pending got v=%b %h want 1 2000", tr[3].vld, tr[3].addr);
    end
    do_reset();
    checks++;
    if (m_axi_arvalid !== 1'b0 || outstanding !== '0 || idle !== 1'b1) begin
      errors++; $display("FAIL midrst_state got v=%b outs=%0d idle=%b want 0 0 1", m_axi_arvalid, outstanding, idle);
    end
    push_req(64'h40, 0);
    run(4);
    checks++;
    if (hs_q.size() != 1 || hs_q[0].addr !== 64'h40 || hs_q[0].len !== 8'd0) begin
      errors++; $display("FAIL midrst_fresh got n=%0d %h/%0d want 1 AR 40/0", hs_q.size(), hs_q[0].addr, hs_q[0].len);
    end
  endtask

  task automatic test_random();
    logic [31:0] r0, r1;
    logic [63:0] a;
    int len, m, hsn, nexp;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      r0 = $urandom;
      r1 = $urandom;
      case ($urandom_range(3))
        0: a = {r0, r1};
        1: a = {r0, r1[31:12], 4'hF, r1[7:0]};
        2: a = 64'hFFFF_FFFF_FFFF_F000 | {52'd0, r1[11:0]};
        default: a = {r0, r1} & 64'hFFFF_FFFF_FFFF_0000;
      endcase
      len = ($urandom_range(1) != 0) ? int'($urandom_range(1023)) : int'($urandom_range(15));
      push_req(a, len);
      model_split(a, len);
    end
    rdy_mode = 1; done_rand = 1'b1; empty_rand = 1'b1;
    while (hs_q.size() < exp_q.size() && tr.size() < 20000) run(50);
    nexp = exp_q.size();
    checks++; if (hs_q.size() != nexp) begin errors++; $display("FAIL rand_count got %0d want %0d", hs_q.size(), nexp); end
    for (int i = 0; i < hs_q.size() && i < nexp; i++) begin
      $display("txn %0d araddr=%h arlen=%0d cyc=%0d", i, hs_q[i].addr, hs_q[i].len, hs_q[i].cyc);
      checks++;
      if (hs_q[i].addr !== exp_q[i].addr || hs_q[i].len !== exp_q[i].len) begin
        errors++; $display("FAIL rand_ar %0d got %h/%0d want %h/%0d", i, hs_q[i].addr, hs_q[i].len, exp_q[i].addr, exp_q[i].len);
      end
    end
    m = 0;
    foreach (tr[i]) begin
      hsn = int'(tr[i].vld && tr[i].rdy);
      checks++;
      if (tr[i].outs !== OW'(m)) begin
        errors++; $display("FAIL rand_outstanding cyc %0d got %0d want %0d", i, tr[i].outs, m);
      end
      checks++;
      if (tr[i].vld && int'(tr[i].outs) >= MO) begin
        errors++; $display("FAIL rand_arvalid_full cyc %0d got arvalid=1 outs=%0d want arvalid=0", i, tr[i].outs);
      end
      checks++;
      if (tr[i].rd && (!tr[i].empty_n || m + hsn - int'(tr[i].done) >= MO)) begin
        errors++; $display("FAIL rand_pop_rule cyc %0d got req_read=1 empty_n=%b after=%0d want no pop", i, tr[i].empty_n, m + hsn - int'(tr[i].done));
      end
      m = m + hsn - int'(tr[i].done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_align();
    test_4k_split();
    test_256_limit();
    test_outstanding();
    test_stall();
    test_reset_mid_split();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
